fmdll_lock_ctrl: RTL

- Parametrised digital lock controller for the next-generation frequency-multiplying DLL.
- Generates the injection/recirculation select, the DCDL delay code and the lock status from phase-detector results sampled once per N reference cycles.
- Replaces the fixed-width Sel/counter logic with a configurable SAR-coarse plus linear-fine search, lock detection and loss-of-lock recovery.
- Sits between the phase-detector/counter logic and the DCDL.

---
 rtl/fmdll_lock_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fmdll_lock_ctrl.sv
// Lock controller for the frequency-multiplying DLL: SAR coarse search, linear fine tracking, lock/unlock detection.
// Define FMDLL_DITHER_FILT_EN so that fine steps need two consecutive same-direction update events.
module fmdll_lock_ctrl #(
   parameter int CODE_W     = 10,
   parameter int N_W        = 4,
   parameter int M_W        = 2,
   parameter int LOCK_CNT   = 8,
   parameter int UNLOCK_CNT = 4
) (
   input  logic              clk_ext,
   input  logic              rst,
   input  logic              en,
   input  logic [M_W-1:0]    M,
   input  logic [N_W-1:0]    N,
   input  logic              pd_valid,
   input  logic              pd_lead,
   input  logic              pd_lag,
   output logic [1:0]        Sel,
   output logic [CODE_W-1:0] code,
   output logic              tick,
   output logic              busy,
   output logic              locked,
   output logic              lock_lost
);

   localparam int BIT_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
   localparam int QC_W  = $clog2(LOCK_CNT + 1);
   localparam int EC_W  = $clog2(UNLOCK_CNT + 1);

   localparam logic [CODE_W-1:0] CODE_MID  = {1'b1, {(CODE_W-1){1'b0}}};
   localparam logic [CODE_W-1:0] CODE_MAX  = {CODE_W{1'b1}};
   localparam logic [CODE_W-1:0] CODE_ZERO = {CODE_W{1'b0}};
   localparam logic [BIT_W-1:0]  BIT_TOP   = BIT_W'(CODE_W - 1);
   localparam logic [QC_W-1:0]   QC_LOCK   = QC_W'(LOCK_CNT);
   localparam logic [EC_W-1:0]   EC_UNLOCK = EC_W'(UNLOCK_CNT);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_COARSE = 3'd2,
      ST_FINE   = 3'd3,
      ST_LOCKED = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      DIR_NONE = 2'b00,
      DIR_UP   = 2'b01,
      DIR_DN   = 2'b10
   } dir_t;

   // Last count of the injection period; N=0 behaves as a period of one cycle.
   function automatic logic [N_W-1:0] period_last(input logic [N_W-1:0] n);
      if (n == {N_W{1'b0}}) begin
         period_last = {N_W{1'b0}};
      end else begin
         period_last = n - N_W'(1'b1);
      end
   endfunction

   // One saturating fine step of the delay code.
   function automatic logic [CODE_W-1:0] step_code(input logic [CODE_W-1:0] c, input dir_t d);
      case (d)
         DIR_UP:  step_code = (c == CODE_MAX)  ? c : c + CODE_W'(1'b1);
         DIR_DN:  step_code = (c == CODE_ZERO) ? c : c - CODE_W'(1'b1);
         default: step_code = c;
      endcase
   endfunction

   state_t             state_r, state_nx;
   logic [CODE_W-1:0]  code_r, code_nx;
   logic [N_W-1:0]     n_cnt_r, n_cnt_nx;
   logic [N_W-1:0]     n_reg_r, n_reg_nx;
   logic [M_W-1:0]     m_reg_r, m_reg_nx;
   logic [M_W-1:0]     settle_r, settle_nx;
   logic [BIT_W-1:0]   bit_r, bit_nx;
   logic [QC_W-1:0]    quiet_r, quiet_nx;
   logic [EC_W-1:0]    err_r, err_nx;
   dir_t               prev_r, prev_nx;
   logic [1:0]         sel_r, sel_nx;
   logic               tick_r, tick_nx;
   logic               busy_r, busy_nx;
   logic               locked_r, locked_nx;
   logic               lost_r, lost_nx;

   dir_t               dir_s;
   dir_t               fdir_s;
   logic               update_s;
   logic               restart_s;
   logic               same_s;

   assign update_s  = tick_r & pd_valid;
   assign restart_s = (state_r != ST_IDLE) && ((M != m_reg_r) || (N != n_reg_r));
   assign same_s    = (fdir_s != DIR_NONE) && (fdir_s == prev_r);

   // Phase-detector direction decode; both or neither flag is quiet.
   always_comb begin
      case ({pd_lead, pd_lag})
         2'b10:   dir_s = DIR_UP;
         2'b01:   dir_s = DIR_DN;
         default: dir_s = DIR_NONE;
      endcase
   end

`ifdef FMDLL_DITHER_FILT_EN
   dir_t pend_r, pend_nx;
   logic fine_act_s;

   assign fine_act_s = en && !restart_s && ((state_r == ST_FINE) || (state_r == ST_LOCKED));

   // Direction filter: a step is released only by the second of two matching update events.
   always_comb begin
      fdir_s  = DIR_NONE;
      pend_nx = pend_r;
      if (!fine_act_s) begin
         pend_nx = DIR_NONE;
      end else if (!update_s) begin
         pend_nx = pend_r;
      end else if (dir_s == DIR_NONE) begin
         pend_nx = DIR_NONE;
      end else if (dir_s == pend_r) begin
         fdir_s  = dir_s;
         pend_nx = DIR_NONE;
      end else begin
         pend_nx = dir_s;
      end
   end

   // Pending-direction register of the filter.
   always_ff @(posedge clk_ext) begin
      if (rst) begin
         pend_r <= DIR_NONE;
      end else begin
         pend_r <= pend_nx;
      end
   end
`else
   // Unfiltered: every update event steps in its own direction.
   always_comb begin
      fdir_s = dir_s;
   end
`endif

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_nx  = state_r;
      code_nx   = code_r;
      n_cnt_nx  = n_cnt_r;
      n_reg_nx  = n_reg_r;
      m_reg_nx  = m_reg_r;
      settle_nx = settle_r;
      bit_nx    = bit_r;
      quiet_nx  = quiet_r;
      err_nx    = err_r;
      prev_nx   = prev_r;
      lost_nx   = 1'b0;

      if (!en) begin
         state_nx  = ST_IDLE;
         n_cnt_nx  = {N_W{1'b0}};
         settle_nx = {M_W{1'b0}};
         quiet_nx  = {QC_W{1'b0}};
         err_nx    = {EC_W{1'b0}};
         prev_nx   = DIR_NONE;
      end else if ((state_r == ST_IDLE) || restart_s) begin
         // Fresh search: a changed M/N restarts quietly, without a lock_lost pulse.
         state_nx  = ST_SETTLE;
         code_nx   = CODE_MID;
         n_cnt_nx  = {N_W{1'b0}};
         n_reg_nx  = N;
         m_reg_nx  = M;
         settle_nx = {M_W{1'b0}};
         quiet_nx  = {QC_W{1'b0}};
         err_nx    = {EC_W{1'b0}};
         prev_nx   = DIR_NONE;
      end else begin
         if (tick_r) begin
            n_cnt_nx = {N_W{1'b0}};
         end else begin
            n_cnt_nx = n_cnt_r + N_W'(1'b1);
         end

         case (state_r)
            ST_SETTLE: begin
               if (tick_r && (settle_r == m_reg_r)) begin
                  state_nx  = ST_COARSE;
                  bit_nx    = BIT_TOP;
                  settle_nx = {M_W{1'b0}};
               end else if (tick_r) begin
                  settle_nx = settle_r + M_W'(1'b1);
               end else begin
                  settle_nx = settle_r;
               end
            end
            ST_COARSE: begin
               if (update_s) begin
                  if (dir_s == DIR_DN) begin
                     code_nx[bit_r] = 1'b0;
                  end else begin
                     code_nx[bit_r] = code_r[bit_r];
                  end
                  if (bit_r != {BIT_W{1'b0}}) begin
                     code_nx[bit_r - BIT_W'(1'b1)] = 1'b1;
                     bit_nx = bit_r - BIT_W'(1'b1);
                  end else begin
                     state_nx = ST_FINE;
                     quiet_nx = {QC_W{1'b0}};
                     err_nx   = {EC_W{1'b0}};
                     prev_nx  = DIR_NONE;
                  end
               end else begin
                  bit_nx = bit_r;
               end
            end
            ST_FINE: begin
               if (update_s) begin
                  code_nx = step_code(code_r, fdir_s);
                  prev_nx = (fdir_s == DIR_NONE) ? prev_r : fdir_s;
                  // Quiet results and dither both count towards lock; a repeated direction means drift.
                  if (same_s) begin
                     quiet_nx = {QC_W{1'b0}};
                  end else begin
                     quiet_nx = quiet_r + QC_W'(1'b1);
                  end
                  if (quiet_nx == QC_LOCK) begin
                     state_nx = ST_LOCKED;
                     err_nx   = {EC_W{1'b0}};
                  end else begin
                     state_nx = ST_FINE;
                  end
               end else begin
                  state_nx = ST_FINE;
               end
            end
            ST_LOCKED: begin
               if (update_s) begin
                  code_nx = step_code(code_r, fdir_s);
                  prev_nx = (fdir_s == DIR_NONE) ? prev_r : fdir_s;
                  if (same_s) begin
                     err_nx = err_r + EC_W'(1'b1);
                  end else begin
                     err_nx = {EC_W{1'b0}};
                  end
                  if (err_nx == EC_UNLOCK) begin
                     state_nx = ST_FINE;
                     lost_nx  = 1'b1;
                     quiet_nx = {QC_W{1'b0}};
                     err_nx   = {EC_W{1'b0}};
                  end else begin
                     state_nx = ST_LOCKED;
                  end
               end else begin
                  state_nx = ST_LOCKED;
               end
            end
            default: begin
               state_nx = ST_IDLE;
            end
         endcase
      end

      if (state_nx == ST_IDLE) begin
         sel_nx = 2'b10;
      end else if (n_cnt_nx == {N_W{1'b0}}) begin
         sel_nx = 2'b01;
      end else begin
         sel_nx = 2'b00;
      end
      tick_nx   = (state_nx != ST_IDLE) && (n_cnt_nx == period_last(n_reg_nx));
      busy_nx   = (state_nx == ST_SETTLE) || (state_nx == ST_COARSE) || (state_nx == ST_FINE);
      locked_nx = (state_nx == ST_LOCKED);
   end

   // Control state and registered outputs; rst overrides every other input.
   always_ff @(posedge clk_ext) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         code_r   <= CODE_ZERO;
         n_cnt_r  <= {N_W{1'b0}};
         n_reg_r  <= {N_W{1'b0}};
         m_reg_r  <= {M_W{1'b0}};
         settle_r <= {M_W{1'b0}};
         bit_r    <= {BIT_W{1'b0}};
         quiet_r  <= {QC_W{1'b0}};
         err_r    <= {EC_W{1'b0}};
         prev_r   <= DIR_NONE;
         sel_r    <= 2'b10;
         tick_r   <= 1'b0;
         busy_r   <= 1'b0;
         locked_r <= 1'b0;
         lost_r   <= 1'b0;
      end else begin
         state_r  <= state_nx;
         code_r   <= code_nx;
         n_cnt_r  <= n_cnt_nx;
         n_reg_r  <= n_reg_nx;
         m_reg_r  <= m_reg_nx;
         settle_r <= settle_nx;
         bit_r    <= bit_nx;
         quiet_r  <= quiet_nx;
         err_r    <= err_nx;
         prev_r   <= prev_nx;
         sel_r    <= sel_nx;
         tick_r   <= tick_nx;
         busy_r   <= busy_nx;
         locked_r <= locked_nx;
         lost_r   <= lost_nx;
      end
   end

   assign Sel       = sel_r;
   assign code      = code_r;
   assign tick      = tick_r;
   assign busy      = busy_r;
   assign locked    = locked_r;
   assign lock_lost = lost_r;

endmodule
